branch_predict_unit: RTL and testbench

Parametrised successor to the single-cycle branch resolver. Adds a direct-mapped branch history/target table, consulted in IF to predict the next PC, and resolves the prediction in EX, redirecting the fetch PC only on a misprediction or halt. Sits between the PC register (IF) and the EX-stage ALU result. Also owns the sticky halt state for the core.

---
 rtl/branch_predict_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped branch history/target table with IF-stage
// lookup, EX-stage resolution/redirect and the core's sticky halt state.
// Optional build macro BPU_STATS_EN adds resolved-branch and mispredict counters.
module branch_predict_unit #(
    parameter int PC_W      = 9,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_valid,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [31:0]       ex_imm,
    input  logic              ex_branch,
    input  logic              ex_jump,
    input  logic              ex_jumpreg,
    input  logic              ex_halt,
    input  logic [31:0]       ex_alu_result,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic [31:0]       pc_four,
    output logic [31:0]       br_pc,
    output logic              pc_sel,
    output logic              halted
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int IDX_W  = $clog2(BHT_DEPTH);
    // The tag may be empty when the PC is too narrow; keep one always-zero bit then.
    localparam int TAG_W  = (PC_W > IDX_W + 2) ? (PC_W - IDX_W - 2) : 0;
    localparam int TAG_WS = (TAG_W > 0) ? TAG_W : 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_HALF    = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic [31:0]       if_pc32;
    logic [31:0]       ex_pc32;
    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  ex_idx;
    logic [TAG_WS-1:0] if_tag;
    logic [TAG_WS-1:0] ex_tag;

    // Zero-extension makes the bits above PC_W zero, so the shifted tag is
    // automatically zero (always matching) when TAG_W is 0.
    assign if_pc32 = 32'(if_pc);
    assign ex_pc32 = 32'(ex_pc);
    assign if_idx  = IDX_W'(if_pc32 >> 2);
    assign ex_idx  = IDX_W'(ex_pc32 >> 2);
    assign if_tag  = TAG_WS'(if_pc32 >> (IDX_W + 2));
    assign ex_tag  = TAG_WS'(ex_pc32 >> (IDX_W + 2));

    logic [BHT_DEPTH-1:0] ent_valid;
    logic [TAG_WS-1:0]    ent_tag [BHT_DEPTH];
    logic [CNT_W-1:0]     ent_cnt [BHT_DEPTH];
    logic [31:0]          ent_tgt [BHT_DEPTH];

    logic                 halted_q, halted_d;
    logic [31:0]          halt_pc_q, halt_pc_d;

    logic                 actual_taken;
    logic [31:0]          res_target;
    logic                 mispredict;
    logic                 ex_hit;
    logic [CNT_W-1:0]     ex_cnt;
    logic                 upd_qual;
    logic                 upd_en;
    logic [CNT_W-1:0]     upd_cnt;
    logic [31:0]          upd_tgt;

    // IF lookup straight from the registered table (no bypass of a same-cycle update)
    always_comb begin
        pred_taken  = ent_valid[if_idx] && (ent_tag[if_idx] == if_tag)
                      && ent_cnt[if_idx][CNT_W-1];
        pred_target = ent_tgt[if_idx];
    end

    // EX resolution and redirect selection, halt has priority over mispredict
    always_comb begin
        actual_taken = (ex_branch && ex_alu_result[0]) || ex_jump;
        res_target   = ex_jumpreg ? ex_alu_result : (ex_pc32 + ex_imm);
        pc_four      = ex_pc32 + 32'd4;
        mispredict   = ex_valid && ((actual_taken != ex_pred_taken)
                       || (actual_taken && (res_target != ex_pred_target)));
        pc_sel       = 1'b0;
        br_pc        = '0;
        if (halted_q) begin
            pc_sel = 1'b1;
            br_pc  = halt_pc_q;
        end else if (ex_valid && ex_halt) begin
            pc_sel = 1'b1;
            br_pc  = ex_pc32;
        end else if (mispredict) begin
            pc_sel = 1'b1;
            br_pc  = actual_taken ? res_target : pc_four;
        end
    end

    // Table update payload: train a hit, allocate on a taken miss, skip otherwise
    always_comb begin
        ex_hit   = ent_valid[ex_idx] && (ent_tag[ex_idx] == ex_tag);
        ex_cnt   = ent_cnt[ex_idx];
        upd_qual = ex_valid && (ex_branch || ex_jump) && !halted_q && !ex_halt;
        upd_en   = 1'b0;
        upd_cnt  = ex_cnt;
        upd_tgt  = ent_tgt[ex_idx];
        if (upd_qual) begin
            if (ex_hit) begin
                upd_en = 1'b1;
                if (actual_taken) begin
                    upd_tgt = res_target;
                    if (ex_cnt != CNT_MAX) upd_cnt = ex_cnt + CNT_W'(1);
                end else if (ex_cnt != '0) begin
                    upd_cnt = ex_cnt - CNT_W'(1);
                end
            end else if (actual_taken) begin
                upd_en  = 1'b1;
                upd_tgt = res_target;
                upd_cnt = ex_jump ? CNT_MAX : CNT_HALF;
            end
        end
    end

    // Per-entry storage; each entry takes the shared payload when it is addressed
    genvar gi;
    generate
        for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_entry
            logic              valid_q, valid_d;
            logic [TAG_WS-1:0] tag_q, tag_d;
            logic [CNT_W-1:0]  cnt_q, cnt_d;
            logic [31:0]       tgt_q, tgt_d;
            logic              wr_sel;

            assign wr_sel = upd_en && (ex_idx == IDX_W'(gi));

            // Next-state of this entry
            always_comb begin
                valid_d = valid_q;
                tag_d   = tag_q;
                cnt_d   = cnt_q;
                tgt_d   = tgt_q;
                if (wr_sel) begin
                    valid_d = 1'b1;
                    tag_d   = ex_tag;
                    cnt_d   = upd_cnt;
                    tgt_d   = upd_tgt;
                end
            end

            // Entry registers; reset leaves counters weakly not-taken
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    tag_q   <= '0;
                    cnt_q   <= CNT_WEAK_NT;
                    tgt_q   <= '0;
                end else begin
                    valid_q <= valid_d;
                    tag_q   <= tag_d;
                    cnt_q   <= cnt_d;
                    tgt_q   <= tgt_d;
                end
            end

            assign ent_valid[gi] = valid_q;
            assign ent_tag[gi]   = tag_q;
            assign ent_cnt[gi]   = cnt_q;
            assign ent_tgt[gi]   = tgt_q;
        end
    endgenerate

    // Sticky halt: the first halting PC is kept until reset
    always_comb begin
        halted_d  = halted_q;
        halt_pc_d = halt_pc_q;
        if (ex_valid && ex_halt && !halted_q) begin
            halted_d  = 1'b1;
            halt_pc_d = ex_pc32;
        end
    end

    // Halt registers
    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q  <= 1'b0;
            halt_pc_q <= '0;
        end else begin
            halted_q  <= halted_d;
            halt_pc_q <= halt_pc_d;
        end
    end

    assign halted = halted_q;

`ifdef BPU_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    // Saturating counts of trained control-flow instructions and their mispredicts
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (upd_qual) begin
            if (stat_br_q != '1) stat_br_d = stat_br_q + 32'd1;
            if (mispredict && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit: directed scenarios plus randomized traffic
// checked against an array-based behavioural model of the prediction table.
module tb_branch_predict_unit;

    localparam int PC_W  = 9;
    localparam int DEPTH = 16;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int CHALF = 1 << (CNT_W - 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [PC_W-1:0]  if_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic [31:0]      ex_imm;
    logic             ex_branch, ex_jump, ex_jumpreg, ex_halt;
    logic [31:0]      ex_alu_result;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;
    logic [31:0]      pc_four, br_pc;
    logic             pc_sel, halted;
`ifdef BPU_STATS_EN
    logic [31:0]      stat_branches, stat_mispredicts;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    branch_predict_unit #(.PC_W(PC_W), .BHT_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jumpreg(ex_jumpreg),
        .ex_halt(ex_halt), .ex_alu_result(ex_alu_result),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .pc_four(pc_four), .br_pc(br_pc), .pc_sel(pc_sel), .halted(halted)
`ifdef BPU_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    int          m_cnt   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    bit          m_halted;
    logic [31:0] m_halt_pc;
    longint      m_stat_br, m_stat_mp;

    function automatic void m_lookup(input int unsigned pc, output bit tk, output logic [31:0] tg);
        int unsigned i = (pc / 4) % DEPTH;
        bit hit = m_valid[i] && (m_tag[i] == pc / (4 * DEPTH));
        tk = hit && (m_cnt[i] >= CHALF);
        tg = m_tgt[i];
    endfunction

    function automatic void m_resolve(output bit sel, output logic [31:0] br, output bit mis,
                                      output bit act, output logic [31:0] tgt);
        logic [31:0] pc = 32'(ex_pc);
        act = (ex_branch && ex_alu_result[0]) || ex_jump;
        tgt = ex_jumpreg ? ex_alu_result : pc + ex_imm;
        mis = ex_valid && ((act != ex_pred_taken) || (act && tgt != ex_pred_target));
        sel = 1'b0;
        br  = 32'd0;
        if (m_halted) begin
            sel = 1'b1; br = m_halt_pc;
        end else if (ex_valid && ex_halt) begin
            sel = 1'b1; br = pc;
        end else if (mis) begin
            sel = 1'b1; br = act ? tgt : pc + 32'd4;
        end
    endfunction

    function automatic void m_commit();
        bit sel, mis, act;
        logic [31:0] br, tgt;
        int unsigned pc = 32'(ex_pc);
        int unsigned i = (pc / 4) % DEPTH;
        bit hit;
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_valid[k] = 1'b0;
                m_cnt[k]   = CHALF - 1;
            end
            m_halted = 1'b0; m_halt_pc = 32'd0; m_stat_br = 0; m_stat_mp = 0;
            return;
        end
        m_resolve(sel, br, mis, act, tgt);
        hit = m_valid[i] && (m_tag[i] == pc / (4 * DEPTH));
        if (ex_valid && (ex_branch || ex_jump) && !m_halted && !ex_halt) begin
            if (m_stat_br < 64'hFFFF_FFFF) m_stat_br++;
            if (mis && m_stat_mp < 64'hFFFF_FFFF) m_stat_mp++;
            if (hit) begin
                if (act) begin
                    m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
                    m_tgt[i] = tgt;
                end else begin
                    m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                end
            end else if (act) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = pc / (4 * DEPTH);
                m_tgt[i]   = tgt;
                m_cnt[i]   = ex_jump ? CMAX : CHALF;
            end
        end
        if (ex_valid && ex_halt && !m_halted) begin
            m_halted = 1'b1; m_halt_pc = 32'(ex_pc);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        m_commit();
        @(negedge clk);
    endtask

    task automatic set_ex(input bit v, input int unsigned pc, input logic [31:0] imm,
                          input bit br, input bit jp, input bit jr, input bit hl,
                          input logic [31:0] alu, input bit ptk, input logic [31:0] ptg);
        ex_valid = v; ex_pc = PC_W'(pc); ex_imm = imm;
        ex_branch = br; ex_jump = jp; ex_jumpreg = jr; ex_halt = hl;
        ex_alu_result = alu; ex_pred_taken = ptk; ex_pred_target = ptg;
    endtask

    task automatic idle_ex();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; idle_ex(); if_pc = 0;
        tick(); tick();
        reset = 1'b0; ex_pc = 9'h1F0; if_pc = 9'h10;
        #1;
        checks_total++; if (pred_taken !== 1'b0) $display("FAIL rst_pred_taken got %b exp 0", pred_taken); else checks_passed++;
        checks_total++; if (pc_sel !== 1'b0) $display("FAIL rst_pc_sel got %b exp 0", pc_sel); else checks_passed++;
        checks_total++; if (br_pc !== 32'd0) $display("FAIL rst_br_pc got %h exp 0", br_pc); else checks_passed++;
        checks_total++; if (halted !== 1'b0) $display("FAIL rst_halted got %b exp 0", halted); else checks_passed++;
        checks_total++; if (pc_four !== 32'h1F4) $display("FAIL rst_pc_four got %h exp 1f4", pc_four); else checks_passed++;
        $display("test_reset done");
        tick();
    endtask

    task automatic test_allocate_taken();
        if_pc = 9'h10;
        set_ex(1, 'h10, 32'h20, 1, 0, 0, 0, 32'h1, 0, 0);
        #1;
        checks_total++; if (pc_sel !== 1'b1) $display("FAIL alloc_pc_sel got %b exp 1", pc_sel); else checks_passed++;
        checks_total++; if (br_pc !== 32'h30) $display("FAIL alloc_br_pc got %h exp 30", br_pc); else checks_passed++;
        checks_total++; if (pred_taken !== 1'b0) $display("FAIL alloc_no_bypass got %b exp 0", pred_taken); else checks_passed++;
        tick();
        idle_ex();
        #1;
        checks_total++; if (pred_taken !== 1'b1) $display("FAIL alloc_pred_taken got %b exp 1", pred_taken); else checks_passed++;
        checks_total++; if (pred_target !== 32'h30) $display("FAIL alloc_pred_target got %h exp 30", pred_target); else checks_passed++;
        $display("test_allocate_taken: br_pc=%h pred_target=%h", 32'h30, pred_target);
        tick();
    endtask

    task automatic test_not_taken_train();
        if_pc = 9'h10;
        set_ex(1, 'h10, 32'h20, 1, 0, 0, 0, 32'h0, 1, 32'h30);
        #1;
        checks_total++; if (pc_sel !== 1'b1) $display("FAIL nt_pc_sel got %b exp 1", pc_sel); else checks_passed++;
        checks_total++; if (br_pc !== 32'h14) $display("FAIL nt_br_pc got %h exp 14", br_pc); else checks_passed++;
        tick();
        idle_ex();
        #1;
        checks_total++; if (pred_taken !== 1'b0) $display("FAIL nt_pred_after1 got %b exp 0", pred_taken); else checks_passed++;
        tick();
        set_ex(1, 'h10, 32'h20, 1, 0, 0, 0, 32'h0, 1, 32'h30);
        tick();
        idle_ex();
        #1;
        checks_total++; if (pred_taken !== 1'b0) $display("FAIL nt_pred_after2 got %b exp 0", pred_taken); else checks_passed++;
        $display("test_not_taken_train: pred_taken=%b", pred_taken);
        tick();
    endtask

    task automatic test_jalr_target();
        if_pc = 9'h08;
        set_ex(1, 'h08, 32'h0, 0, 1, 1, 0, 32'h44, 1, 32'h40);
        #1;
        checks_total++; if (pc_sel !== 1'b1) $display("FAIL jalr_pc_sel got %b exp 1", pc_sel); else checks_passed++;
        checks_total++; if (br_pc !== 32'h44) $display("FAIL jalr_br_pc got %h exp 44", br_pc); else checks_passed++;
        tick();
        idle_ex();
        #1;
        checks_total++; if (pred_taken !== 1'b1) $display("FAIL jalr_pred_taken got %b exp 1", pred_taken); else checks_passed++;
        checks_total++; if (pred_target !== 32'h44) $display("FAIL jalr_pred_target got %h exp 44", pred_target); else checks_passed++;
        $display("test_jalr_target: br_pc=44 pred_target=%h", pred_target);
        tick();
    endtask

    task automatic test_saturation();
        if_pc = 9'h20;
        set_ex(1, 'h20, 32'h100, 1, 0, 0, 0, 32'h1, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_ex(1, 'h20, 32'h100, 1, 0, 0, 0, 32'h1, 1, 32'h120);
            #1;
            checks_total++; if (pc_sel !== 1'b0) $display("FAIL sat_correct_pc_sel[%0d] got %b exp 0", k, pc_sel); else checks_passed++;
            tick();
        end
        idle_ex();
        #1;
        checks_total++; if (pred_taken !== 1'b1) $display("FAIL sat_pred_top got %b exp 1", pred_taken); else checks_passed++;
        checks_total++; if (pred_target !== 32'h120) $display("FAIL sat_pred_target got %h exp 120", pred_target); else checks_passed++;
        // Counter at 3 (not wrapped): one not-taken still predicts taken
        set_ex(1, 'h20, 32'h100, 1, 0, 0, 0, 32'h0, 1, 32'h120);
        #1;
        checks_total++; if (br_pc !== 32'h24) $display("FAIL sat_nt_br_pc got %h exp 24", br_pc); else checks_passed++;
        tick();
        idle_ex();
        #1;
        checks_total++; if (pred_taken !== 1'b1) $display("FAIL sat_after_dec1 got %b exp 1", pred_taken); else checks_passed++;
        set_ex(1, 'h20, 32'h100, 1, 0, 0, 0, 32'h0, 1, 32'h120);
        tick();
        idle_ex();
        #1;
        checks_total++; if (pred_taken !== 1'b0) $display("FAIL sat_after_dec2 got %b exp 0", pred_taken); else checks_passed++;
        $display("test_saturation: pred_taken=%b", pred_taken);
        tick();
    endtask

    task automatic test_halt();
        if_pc = 9'h1C;
        set_ex(1, 'h1C, 32'h4, 1, 0, 0, 1, 32'h1, 0, 0);
        #1;
        checks_total++; if (br_pc !== 32'h1C) $display("FAIL halt_br_pc got %h exp 1c", br_pc); else checks_passed++;
        checks_total++; if (pc_sel !== 1'b1) $display("FAIL halt_pc_sel got %b exp 1", pc_sel); else checks_passed++;
        tick();
        idle_ex();
        #1;
        checks_total++; if (halted !== 1'b1) $display("FAIL halt_sticky got %b exp 1", halted); else checks_passed++;
        checks_total++; if (br_pc !== 32'h1C) $display("FAIL halt_hold_br_pc got %h exp 1c", br_pc); else checks_passed++;
        checks_total++; if (pred_taken !== 1'b0) $display("FAIL halt_table_1c got %b exp 0", pred_taken); else checks_passed++;
        // Updates and further halts are ignored while halted
        set_ex(1, 'h20, 32'h100, 1, 0, 0, 0, 32'h1, 0, 0);
        tick();
        set_ex(1, 'h40, 32'h0, 0, 0, 0, 1, 32'h0, 0, 0);
        #1;
        checks_total++; if (br_pc !== 32'h1C) $display("FAIL halt_second_br_pc got %h exp 1c", br_pc); else checks_passed++;
        tick();
        idle_ex(); if_pc = 9'h20;
        #1;
        checks_total++; if (pred_taken !== 1'b0) $display("FAIL halt_no_update got %b exp 0", pred_taken); else checks_passed++;
        checks_total++; if (pc_sel !== 1'b1) $display("FAIL halt_pc_sel_late got %b exp 1", pc_sel); else checks_passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks_total++; if (halted !== 1'b0) $display("FAIL halt_reset_halted got %b exp 0", halted); else checks_passed++;
        checks_total++; if (pc_sel !== 1'b0) $display("FAIL halt_reset_pc_sel got %b exp 0", pc_sel); else checks_passed++;
        $display("test_halt: halted cleared by reset, halted=%b", halted);
        tick();
    endtask

`ifdef BPU_STATS_EN
    task automatic test_stats();
        reset = 1'b1; idle_ex(); tick(); reset = 1'b0;
        set_ex(1, 'h40, 32'h10, 1, 0, 0, 0, 32'h1, 0, 0);        tick(); // mispredict
        set_ex(0, 'h40, 32'h10, 1, 0, 0, 0, 32'h1, 0, 0);        tick(); // not valid
        set_ex(1, 'h40, 32'h10, 1, 0, 0, 0, 32'h1, 1, 32'h50);   tick();
        set_ex(1, 'h80, 32'h8, 0, 1, 0, 0, 32'h0, 0, 0);         tick(); // mispredict
        set_ex(1, 'h44, 32'h0, 0, 0, 0, 0, 32'h1, 1, 32'h9);     tick(); // not control flow
        set_ex(1, 'h40, 32'h10, 1, 0, 0, 0, 32'h1, 1, 32'h50);   tick();
        set_ex(1, 'h40, 32'h10, 1, 0, 0, 0, 32'h1, 1, 32'h50);   tick();
        idle_ex();
        #1;
        checks_total++; if (stat_branches !== 32'd5) $display("FAIL stat_branches got %0d exp 5", stat_branches); else checks_passed++;
        checks_total++; if (stat_mispredicts !== 32'd2) $display("FAIL stat_mispredicts got %0d exp 2", stat_mispredicts); else checks_passed++;
        reset = 1'b1; tick(); reset = 1'b0;
        #1;
        checks_total++; if (stat_branches !== 32'd0) $display("FAIL stat_br_reset got %0d exp 0", stat_branches); else checks_passed++;
        checks_total++; if (stat_mispredicts !== 32'd0) $display("FAIL stat_mp_reset got %0d exp 0", stat_mispredicts); else checks_passed++;
        $display("test_stats: branches=5 mispredicts=2 then cleared");
        tick();
    endtask
`endif

    task automatic test_random();
        int unsigned pool [8] = '{'h10, 'h50, 'h90, 'h14, 'h08, 'h1C, 'h3C, 'h7C};
        int errs_before = checks_total - checks_passed;
        reset = 1'b1; idle_ex(); tick(); reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit e_tk, p_tk, e_sel, e_mis, e_act;
            logic [31:0] e_tg, p_tg, e_br, e_tgt;
            int unsigned pc;
            int kind;
            reset = ($urandom_range(0, 149) == 0);
            if_pc = ($urandom_range(0, 1) == 0) ? PC_W'(pool[$urandom_range(0, 7)])
                                                : PC_W'($urandom_range(0, 511));
            pc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : pool[$urandom_range(0, 7)];
            kind = $urandom_range(0, 9);
            m_lookup(pc, p_tk, p_tg);
            if ($urandom_range(0, 1) == 0) begin
                p_tk = $urandom_range(0, 1);
                p_tg = ($urandom_range(0, 1) == 0) ? $urandom : p_tg;
            end
            set_ex($urandom_range(0, 3) != 0, pc,
                   ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63) * 4),
                   kind <= 5, kind == 6 || kind == 7, kind == 7,
                   $urandom_range(0, 399) == 0,
                   ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1)) : $urandom,
                   p_tk, p_tg);
            #1;
            m_lookup(32'(if_pc), e_tk, e_tg);
            m_resolve(e_sel, e_br, e_mis, e_act, e_tgt);
            checks_total++; if (pred_taken !== e_tk) $display("FAIL rnd_pred_taken[%0d] got %b exp %b", n, pred_taken, e_tk); else checks_passed++;
            if (e_tk) begin
                checks_total++; if (pred_target !== e_tg) $display("FAIL rnd_pred_target[%0d] got %h exp %h", n, pred_target, e_tg); else checks_passed++;
            end
            checks_total++; if (pc_sel !== e_sel) $display("FAIL rnd_pc_sel[%0d] got %b exp %b", n, pc_sel, e_sel); else checks_passed++;
            checks_total++; if (br_pc !== e_br) $display("FAIL rnd_br_pc[%0d] got %h exp %h", n, br_pc, e_br); else checks_passed++;
            checks_total++; if (pc_four !== 32'(ex_pc) + 32'd4) $display("FAIL rnd_pc_four[%0d] got %h exp %h", n, pc_four, 32'(ex_pc) + 32'd4); else checks_passed++;
            checks_total++; if (halted !== m_halted) $display("FAIL rnd_halted[%0d] got %b exp %b", n, halted, m_halted); else checks_passed++;
`ifdef BPU_STATS_EN
            checks_total++; if (stat_branches !== 32'(m_stat_br)) $display("FAIL rnd_stat_br[%0d] got %0d exp %0d", n, stat_branches, m_stat_br); else checks_passed++;
            checks_total++; if (stat_mispredicts !== 32'(m_stat_mp)) $display("FAIL rnd_stat_mp[%0d] got %0d exp %0d", n, stat_mispredicts, m_stat_mp); else checks_passed++;
`endif
            tick();
        end
        reset = 1'b0;
        $display("test_random: 3000 cycles, new failures %0d", (checks_total - checks_passed) - errs_before);
    endtask

    initial begin
        reset = 1'b1; if_pc = 0; idle_ex();
        test_reset();
        test_allocate_taken();
        test_not_taken_train();
        test_jalr_target();
        test_saturation();
        test_halt();
`ifdef BPU_STATS_EN
        test_stats();
`endif
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
